// File: rtl/matriz_feeder.sv
// Sequencer/collector for a 4-element systolic ring computing y = A*x on a 4x4 matrix.
// Optional sticky dropped-write flag `wr_err` is built when MATRIZ_FEEDER_WRERR_EN is defined.
module matriz_feeder #(
  parameter int W     = 16,
  parameter int DRAIN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         ring_load,
`ifdef MATRIZ_FEEDER_WRERR_EN
  output logic         wr_err,
`endif
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic [W-1:0] x3,
  output logic [W-1:0] x4,
  output logic [W-1:0] a1,
  output logic [W-1:0] a2,
  output logic [W-1:0] a3,
  output logic [W-1:0] a4,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] y3,
  input  logic [W-1:0] y4,
  output logic [W-1:0] res1,
  output logic [W-1:0] res2,
  output logic [W-1:0] res3,
  output logic [W-1:0] res4
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [2:0] DrainLast = (DRAIN == 0) ? 3'd0 : 3'(DRAIN - 1);

  state_e       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [2:0]   drain_q, drain_d;

  logic [W-1:0] mat_q [16];
  logic [W-1:0] vec_q [4];
  logic [W-1:0] a_q [4];
  logic [W-1:0] a_d [4];
  logic [W-1:0] res_q [4];
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         load_q, load_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      drain_q <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_RUN;
        step_d  = 2'd0;
      end
      S_RUN: begin
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
          drain_d = 3'd0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == DrainLast) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops below present them
  // in the same cycle the FSM occupies that state.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    load_d = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
    for (int k = 0; k < 4; k++) begin
      a_d[k] = '0;
      if (state_d == S_RUN) a_d[k] = mat_q[{2'(k), 2'(2'(k) - step_d)}];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      load_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      load_q <= load_d;
      for (int k = 0; k < 4; k++) a_q[k] <= a_d[k];
      if (state_d == S_DONE) begin
        res_q[0] <= y1;
        res_q[1] <= y2;
        res_q[2] <= y3;
        res_q[3] <= y4;
      end
    end
  end

  // Host storage only accepts writes while idle; addresses 20..31 fall through.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mat_q[i] <= '0;
      for (int i = 0; i < 4; i++)  vec_q[i] <= '0;
    end else if (wr_en && state_q == S_IDLE) begin
      if (!wr_addr[4])                 mat_q[wr_addr[3:0]] <= wr_data;
      else if (wr_addr[3:2] == 2'b00)  vec_q[wr_addr[1:0]] <= wr_data;
    end
  end

`ifdef MATRIZ_FEEDER_WRERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset)                                   err_q <= 1'b0;
    else if (wr_en && state_q != S_IDLE)          err_q <= 1'b1;
    else if (wr_en && wr_addr == 5'd31)           err_q <= 1'b0;
  end

  assign wr_err = err_q;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign ring_load = load_q;
  assign x1   = vec_q[0];
  assign x2   = vec_q[1];
  assign x3   = vec_q[2];
  assign x4   = vec_q[3];
  assign a1   = a_q[0];
  assign a2   = a_q[1];
  assign a3   = a_q[2];
  assign a4   = a_q[3];
  assign res1 = res_q[0];
  assign res2 = res_q[1];
  assign res3 = res_q[2];
  assign res4 = res_q[3];

endmodule

// File: tb/tb_matriz_feeder.sv
// Scoreboard bench for matriz_feeder: a cycle-indexed reference model predicts every output,
// and a negedge monitor pops expected done/result records from a queue.
module tb_matriz_feeder;

  localparam int W    = 16;
  localparam int D    = 1;
  localparam int MAXC = 2048;

  logic         clk = 1'b0;
  logic         reset, wr_en, start;
  logic [4:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         busy, done, ring_load;
`ifdef MATRIZ_FEEDER_WRERR_EN
  logic         wr_err;
`endif
  logic [W-1:0] x1, x2, x3, x4, a1, a2, a3, a4;
  logic [W-1:0] y1, y2, y3, y4, res1, res2, res3, res4;

  matriz_feeder #(.W(W), .DRAIN(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .ring_load(ring_load),
`ifdef MATRIZ_FEEDER_WRERR_EN
    .wr_err(wr_err),
`endif
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [4*W-1:0] res;
  } doneRec_t;

  doneRec_t       doneQ [$];
  bit             expBusy [MAXC];
  bit             expLoad [MAXC];
  bit             expErr  [MAXC];
  logic [4*W-1:0] expA    [MAXC];
  logic [4*W-1:0] expX    [MAXC];
  logic [4*W-1:0] expRes  [MAXC];
  logic [4*W-1:0] yTab    [MAXC];
  logic [W-1:0]   mdlMat  [16];
  logic [W-1:0]   mdlVec  [4];
  bit             mdlErr = 1'b0;
  bit             monOn  = 1'b0;
  int             checks = 0;
  int             failures = 0;

  // Mock ring: y changes every cycle, so capture timing errors show up as wrong results.
  always @(posedge clk) begin
    #2;
    if (cyc < MAXC) {y4, y3, y2, y1} = yTab[cyc];
  end

  task automatic cmp(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic scheduleRun(input int c0);
    doneRec_t r;
    int cd;
    cd = c0 + 6 + D;
    for (int cc = c0 + 1; cc <= cd; cc++) expBusy[cc] = 1'b1;
    expLoad[c0 + 1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic [4*W-1:0] v;
      for (int k = 0; k < 4; k++) v[k*W +: W] = mdlMat[4*k + (k - t + 4) % 4];
      expA[c0 + 2 + t] = v;
    end
    r.cyc = cd;
    r.res = yTab[cd - 1];
    doneQ.push_back(r);
    for (int cc = cd; cc < MAXC; cc++) expRes[cc] = r.res;
  endtask

  task automatic applyStimulus(input bit rstN, input bit st, input bit we,
                               input logic [4:0] addr, input logic [W-1:0] data);
    int  c;
    int  ad;
    bit  idle;
    @(posedge clk);
    #1;
    reset   = rstN;
    start   = st;
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    c  = cyc;
    ad = int'(addr);
    if (!rstN) begin
      for (int i = 0; i < 16; i++) mdlMat[i] = '0;
      for (int i = 0; i < 4; i++)  mdlVec[i] = '0;
      mdlErr = 1'b0;
      for (int cc = c + 1; cc < MAXC; cc++) begin
        expBusy[cc] = 1'b0;
        expLoad[cc] = 1'b0;
        expErr[cc]  = 1'b0;
        expA[cc]    = '0;
        expX[cc]    = '0;
        expRes[cc]  = '0;
      end
      while (doneQ.size() > 0 && doneQ[$].cyc > c) void'(doneQ.pop_back());
    end else begin
      idle = !expBusy[c];
      if (we) begin
        if (idle) begin
          if (ad < 16)      mdlMat[ad] = data;
          else if (ad < 20) mdlVec[ad - 16] = data;
          if (ad == 31)     mdlErr = 1'b0;
        end else begin
          mdlErr = 1'b1;
        end
        for (int cc = c + 1; cc < MAXC; cc++) begin
          expX[cc]   = {mdlVec[3], mdlVec[2], mdlVec[1], mdlVec[0]};
          expErr[cc] = mdlErr;
        end
      end
      if (st && idle) scheduleRun(c);
    end
  endtask

  task automatic checkOutput();
    doneRec_t r;
    if (!monOn || cyc < 1 || cyc >= MAXC) return;
    cmp("busy", 64'(busy), 64'(expBusy[cyc]));
    cmp("ring_load", 64'(ring_load), 64'(expLoad[cyc]));
    cmp("coeff", {a4, a3, a2, a1}, expA[cyc]);
    cmp("xvec", {x4, x3, x2, x1}, expX[cyc]);
    cmp("res_hold", {res4, res3, res2, res1}, expRes[cyc]);
`ifdef MATRIZ_FEEDER_WRERR_EN
    cmp("wr_err", 64'(wr_err), 64'(expErr[cyc]));
`endif
    if (done) begin
      if (doneQ.size() == 0) begin
        cmp("unexpected_done", 64'(done), 64'(0));
      end else begin
        r = doneQ.pop_front();
        cmp("done_cycle", 64'(cyc), 64'(r.cyc));
        cmp("done_res", {res4, res3, res2, res1}, r.res);
      end
    end else if (doneQ.size() > 0 && doneQ[0].cyc <= cyc) begin
      r = doneQ.pop_front();
      cmp("missed_done", 64'(done), 64'(1));
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, '0);
  endtask

  task automatic writeWord(input logic [4:0] addr, input logic [W-1:0] data);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    y1 = '0; y2 = '0; y3 = '0; y4 = '0;
    for (int i = 0; i < MAXC; i++) begin
      yTab[i]   = {$urandom, $urandom};
      expA[i]   = '0;
      expX[i]   = '0;
      expRes[i] = '0;
    end
    for (int i = 0; i < 16; i++) mdlMat[i] = '0;
    for (int i = 0; i < 4; i++)  mdlVec[i] = '0;
    monOn = 1'b1;

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0);

    // Coefficient skew pattern A[i][j] = 4i+j+1, x = 1..4.
    for (int i = 0; i < 16; i++) writeWord(5'(i), W'(i + 1));
    for (int i = 0; i < 4; i++)  writeWord(5'(16 + i), W'(i + 1));
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idleCycles(10);

    // Write and repeated start while busy must both be dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd16, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idleCycles(10);
    writeWord(5'd31, '0);
    idleCycles(2);

    // Back-to-back runs with start held high.
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idleCycles(12);

    // Reset for two cycles in the middle of RUN, then a clean run.
    for (int i = 0; i < 16; i++) writeWord(5'(i), W'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, '0);
    idleCycles(2);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0);
    idleCycles(4);
    for (int i = 0; i < 20; i++) writeWord(5'(i), W'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd17, 16'h1234);
    idleCycles(10);

    // Randomized traffic: writes anywhere, sporadic starts and rare resets.
    repeat (300) begin
      applyStimulus(($urandom_range(0, 79) != 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 31)), W'($urandom));
    end
    idleCycles(15);

    cmp("pending_done", 64'(doneQ.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
